seq_booth_mul: RTL and testbench



---
 rtl/seq_booth_mul_if.sv | 23 ++
 rtl/seq_booth_mul.sv | 97 +++++++++
 tb/tb_seq_booth_mul.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/seq_booth_mul_if.sv
// rtl/seq_booth_mul_if.sv - start/operand/result bundle for the sequential Booth multiplier
interface seq_booth_mul_if #(
    parameter int N = 16
);
    logic             start;
    logic [N-1:0]     a;
    logic [N-1:0]     b;
    logic             busy;
    logic             done;
    logic [2*N-1:0]   product;

    // Requester side: issues operands, observes status and result
    modport master (
        output start, a, b,
        input  busy, done, product
    );

    // Multiplier side
    modport slave (
        input  start, a, b,
        output busy, done, product
    );
endinterface

// File: rtl/seq_booth_mul.sv
// rtl/seq_booth_mul.sv - radix-2 Booth multiplier, one step per clock, registered product
module seq_booth_mul #(
    parameter int N = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    seq_booth_mul_if.slave bus
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t          state;
    logic [N:0]      acc;
    logic [N:0]      m;
    logic [N-1:0]    q;
    logic            q_m1;
    logic [CW-1:0]   cnt;
    logic            busy_r;
    logic            done_r;
    logic [2*N-1:0]  prod_r;

    logic [N:0]      sum;
    logic [N:0]      acc_n;
    logic [N-1:0]    q_n;

    // One Booth step: add/subtract multiplicand per {q[0], q_m1}, then arithmetic shift right.
    // acc carries an extra bit so acc - m cannot wrap when a is the most negative value.
    always_comb begin
        sum = acc;
        case ({q[0], q_m1})
            2'b01:   sum = acc + m;
            2'b10:   sum = acc - m;
            default: sum = acc;
        endcase
        acc_n = {sum[N], sum[N:1]};
        q_n   = {sum[0], q[N-1:1]};
    end

    // Control FSM with datapath registers and registered status/result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            acc    <= '0;
            m      <= '0;
            q      <= '0;
            q_m1   <= 1'b0;
            cnt    <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            prod_r <= '0;
        end else begin
            case (state)
                IDLE, FIN: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        acc    <= '0;
                        q      <= bus.b;
                        q_m1   <= 1'b0;
                        m      <= {bus.a[N-1], bus.a};
                        cnt    <= '0;
                        busy_r <= 1'b1;
                        state  <= CALC;
                    end else begin
                        busy_r <= 1'b0;
                        state  <= IDLE;
                    end
                end
                CALC: begin
                    acc  <= acc_n;
                    q    <= q_n;
                    q_m1 <= q[0];
                    cnt  <= cnt + 1'b1;
                    if (cnt == CW'(N - 1)) begin
                        prod_r <= {acc_n[N-1:0], q_n};
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        state  <= FIN;
                    end
                end
                default: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.product = prod_r;
endmodule

// File: tb/tb_seq_booth_mul.sv
// tb/tb_seq_booth_mul.sv - directed and random checks of seq_booth_mul against a cycle model
module tb_seq_booth_mul;
    localparam int N = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    seq_booth_mul_if #(.N(N)) bus ();

    seq_booth_mul #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mul_ref(input logic signed [15:0] x, input logic signed [15:0] y);
        logic signed [31:0] xx;
        logic signed [31:0] yy;
        xx = x;
        yy = y;
        return 32'(xx * yy);
    endfunction

    // Model: an accepted start produces a*b exactly N clocks later; starts are ignored while busy
    int          remaining = 0;
    logic [31:0] pend = '0;
    logic [31:0] mprod = '0;
    logic        mdone = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remaining <= 0;
            mprod     <= '0;
            mdone     <= 1'b0;
        end else begin
            mdone <= 1'b0;
            if (remaining > 0) begin
                remaining <= remaining - 1;
                if (remaining == 1) begin
                    mprod <= pend;
                    mdone <= 1'b1;
                end
            end else if (bus.start) begin
                pend      <= mul_ref(bus.a, bus.b);
                remaining <= N;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Issue a start with operands just after a rising edge so it is sampled at the next edge (T0)
    task automatic issue(input logic [15:0] x, input logic [15:0] y);
        bus.a = x;
        bus.b = y;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Count edges after T0 until done is seen; 0 means the bound expired
    task automatic wait_done(output int k);
        k = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                k = i;
                break;
            end
        end
    endtask

    task automatic run_op(input string name, input logic [15:0] x, input logic [15:0] y,
                          input logic [31:0] exp);
        int k;
        issue(x, y);
        wait_done(k);
        check({name, "_latency"}, 32'(k), 32'(N));
        check(name, bus.product, exp);
    endtask

    task automatic no_done_for(input string name, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) seen++;
        end
        check(name, 32'(seen), 32'd0);
    endtask

    initial begin
        int k;
        logic [15:0] ra;
        logic [15:0] rb;

        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;

        fork
            // Per-cycle comparison of DUT outputs against the model
            forever begin
                @(negedge clk);
                check("cyc_busy", 32'(bus.busy), 32'(remaining > 0));
                check("cyc_done", 32'(bus.done), 32'(mdone));
                check("cyc_product", bus.product, mprod);
                check("cyc_busy_done_excl", 32'(bus.busy & bus.done), 32'd0);
            end
        join_none

        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("rst_busy", 32'(bus.busy), 32'd0);
            check("rst_done", 32'(bus.done), 32'd0);
            check("rst_product", bus.product, 32'h0000_0000);
        end

        run_op("mul_3x5", 16'd3, 16'd5, 32'h0000_000F);
        @(posedge clk); #1;
        check("done_one_cycle", 32'(bus.done), 32'd0);
        run_op("mul_m7x6", 16'hFFF9, 16'd6, 32'hFFFF_FFD6);
        run_op("mul_max_min", 16'h7FFF, 16'h8000, 32'hC000_8000);
        run_op("mul_min_min", 16'h8000, 16'h8000, 32'h4000_0000);

        // Start during CALC must be ignored
        issue(16'd2, 16'd2);
        k = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (i == 5) begin
                bus.a = 16'd9;
                bus.b = 16'd9;
                bus.start = 1'b1;
            end
            if (i == 6) bus.start = 1'b0;
            if (bus.done) begin
                k = i;
                break;
            end
        end
        check("ignored_start_latency", 32'(k), 32'(N));
        check("ignored_start_product", bus.product, 32'h0000_0004);
        no_done_for("ignored_start_no_second_done", 20);

        // Back-to-back: restart while in FIN
        issue(16'd100, 16'hFFFF);
        wait_done(k);
        check("b2b_first_latency", 32'(k), 32'(N));
        check("b2b_first", bus.product, 32'hFFFF_FF9C);
        issue(16'hFFFF, 16'hFFFF);
        wait_done(k);
        check("b2b_second_latency", 32'(k), 32'(N));
        check("b2b_second", bus.product, 32'h0000_0001);
        repeat (3) @(posedge clk);
        #1;

        // Reset mid-operation abandons the multiply
        issue(16'd5, 16'd5);
        repeat (7) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_done", 32'(bus.done), 32'd0);
        check("midrst_product", bus.product, 32'h0000_0000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        no_done_for("midrst_no_done", 20);
        check("midrst_product_after", bus.product, 32'h0000_0000);
        run_op("mul_4x4", 16'd4, 16'd4, 32'h0000_0010);

        // Random operands against the signed reference
        for (int i = 0; i < 200; i++) begin
            ra = 16'($random);
            rb = 16'($random);
            if (i == 0) ra = 16'h8000;
            if (i == 1) rb = 16'h0000;
            run_op("rand", ra, rb, mul_ref(ra, rb));
        end

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
